// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_pipe_pkg                                                  |
// | Brief    : Shared encodings for the EX/MEM pipeline slice                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package riscv_pipe_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] RESULT_SRC_ALU = 2'd0;
    localparam logic [1:0] RESULT_SRC_MEM = 2'd1;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'd2;

    localparam int         ST_W       = 1;
    localparam logic [ST_W-1:0] ST_IDLE   = 1'b0;
    localparam logic [ST_W-1:0] ST_SQUASH = 1'b1;

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_resolve                                                  |
// | Brief    : Maps funct3 and ALU flags to the branch condition               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module branch_resolve
    import riscv_pipe_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       gte,
    output logic       cond
);

    // Signed compares run through slt in EX, so blt/bge read the zero flag.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = ~zero;
            F3_BGE:  cond = zero;
            F3_BLTU: cond = lt;
            F3_BGEU: cond = gte;
            default: cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ex_mem_stage                                                    |
// | Brief    : EX/MEM register with branch resolve, redirect and squash FSM.   |
// |            Optional perf counters when EX_MEM_PERF_CNT_EN is defined.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ex_mem_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            zero,
    input  logic            lt,
    input  logic            gte,
    input  logic [2:0]      funct3,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] pc_target_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [XLEN-1:0] write_data_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic            mem_write_i,
    input  logic [1:0]      result_src_i,
    output logic            valid_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] write_data_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            mem_write_o,
    output logic [1:0]      result_src_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     taken_cnt_o,
`endif
    output logic            squash_o
);

    localparam int             c_cnt_w = 2;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(SQUASH_DEPTH);

    logic [ST_W-1:0]    r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;
    logic [XLEN-1:0]    r_alu_result;
    logic [XLEN-1:0]    r_write_data;
    logic [4:0]         r_rd;
    logic               r_reg_write;
    logic               r_mem_write;
    logic [1:0]         r_result_src;
    logic [XLEN-1:0]    r_pc_plus4;
    logic               r_redirect;
    logic [XLEN-1:0]    r_redirect_pc;

    logic w_cond;
    logic w_valid_eff;
    logic w_taken;

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .gte    (gte),
        .cond   (w_cond)
    );

    // Anything arriving while squashing is on the wrong path and becomes a bubble.
    assign w_valid_eff = valid_i & ~flush_i & (r_state == ST_IDLE);
    assign w_taken     = w_valid_eff & (jump_i | (branch_i & w_cond));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_valid       <= 1'b0;
            r_alu_result  <= '0;
            r_write_data  <= '0;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_result_src  <= '0;
            r_pc_plus4    <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (flush_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_redirect  <= 1'b0;
        end else if (stall_i) begin
            r_redirect <= 1'b0;
        end else begin
            r_valid     <= w_valid_eff;
            r_reg_write <= reg_write_i & w_valid_eff;
            r_mem_write <= mem_write_i & w_valid_eff;
            r_redirect  <= w_taken;
            if (w_valid_eff) begin
                r_alu_result <= ALUResult;
                r_write_data <= write_data_i;
                r_rd         <= rd_i;
                r_result_src <= result_src_i;
                r_pc_plus4   <= pc_plus4_i;
            end
            if (w_taken) begin
                r_redirect_pc <= pc_target_i;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_taken) begin
                        r_state <= ST_SQUASH;
                        r_cnt   <= c_depth;
                    end
                end
                ST_SQUASH: begin
                    if (r_cnt <= 2'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_taken_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (!stall_i && !flush_i) begin
            if (w_valid_eff && (branch_i || jump_i)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign br_cnt_o    = r_br_cnt;
    assign taken_cnt_o = r_taken_cnt;
`endif

    assign valid_o       = r_valid;
    assign alu_result_o  = r_alu_result;
    assign write_data_o  = r_write_data;
    assign rd_o          = r_rd;
    assign reg_write_o   = r_reg_write;
    assign mem_write_o   = r_mem_write;
    assign result_src_o  = r_result_src;
    assign pc_plus4_o    = r_pc_plus4;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign squash_o      = (r_state == ST_SQUASH);

endmodule
`default_nettype wire
